// File: rtl/instr_decode_stage.sv
// Registered RV32I/RV64I decode stage: extracts register and function fields, classifies
// the instruction format, builds the sign-extended immediate and holds the result behind
// a valid/ready handshake with flush.
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  fmt_e              w_fmt;
  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic              w_rs1_used;
  logic              w_rs2_used;
  logic              w_rd_we;
  logic              w_in_ready;
  logic              w_load;

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_instr;
  logic [2:0]        r_fmt;
  logic [XLEN-1:0]   r_imm;
  logic              r_rs1_used;
  logic              r_rs2_used;
  logic              r_rd_we;

  // The full opcode includes instr[1:0], so any compressed encoding falls to default.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fmt = FMT_ILL;
    case (in_instr[6:0])
      7'b0110011:                          w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0001111, 7'b1110011:              w_fmt = FMT_I;
      7'b0100011:                          w_fmt = FMT_S;
      7'b1100011:                          w_fmt = FMT_B;
      7'b0110111, 7'b0010111:              w_fmt = FMT_U;
      7'b1101111:                          w_fmt = FMT_J;
      default:                             w_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Every 32-bit immediate already carries instr[31] in its top bit, so widening is a sign extension.
  assign w_imm      = XLEN'($signed(w_imm32));
  assign w_rs1_used = w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign w_rs2_used = w_fmt inside {FMT_R, FMT_S, FMT_B};
  assign w_rd_we    = (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_instr[11:7] != 5'd0);

  assign w_in_ready = !r_valid || out_ready;
  assign w_load     = in_valid && w_in_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_instr    <= '0;
      r_fmt      <= '0;
      r_imm      <= '0;
      r_rs1_used <= 1'b0;
      r_rs2_used <= 1'b0;
      r_rd_we    <= 1'b0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_load)    r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;

      if (w_load) begin
        r_pc       <= in_pc;
        r_instr    <= in_instr;
        r_fmt      <= w_fmt;
        r_imm      <= w_imm;
        r_rs1_used <= w_rs1_used;
        r_rs2_used <= w_rs2_used;
        r_rd_we    <= w_rd_we;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_opcode   = r_instr[6:0];
  assign out_rd       = r_instr[11:7];
  assign out_funct3   = r_instr[14:12];
  assign out_rs1      = r_instr[19:15];
  assign out_rs2      = r_instr[24:20];
  assign out_funct7   = r_instr[31:25];
  assign out_fmt      = r_fmt;
  assign out_imm      = r_imm;
  assign out_rs1_used = r_rs1_used;
  assign out_rs2_used = r_rs2_used;
  assign out_rd_we    = r_rd_we;
  assign out_illegal  = (r_fmt == FMT_ILL);

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus a scoreboard that
// predicts every decoded entry from a reference model and compares it when consumed.
module tb_instr_decode_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_rd_we;
  logic            out_illegal;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic            illegal;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instr_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
    .out_fmt(out_fmt), .out_imm(out_imm),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference decode written directly from the RISC-V encoding tables.
  function automatic exp_t model(input logic [31:0] i, input logic [PC_W-1:0] pc);
    exp_t e;
    logic [31:0] imm;
    e = '0;
    e.pc = pc;
    e.opcode = i[6:0]; e.rd = i[11:7]; e.funct3 = i[14:12];
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.funct7 = i[31:25];
    imm = 32'd0;
    case (i[6:0])
      7'h33: begin e.fmt = 3'd0; e.rs1_used = 1; e.rs2_used = 1; e.rd_we = 1; end
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        e.fmt = 3'd1; e.rs1_used = 1; e.rd_we = 1;
        imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        e.fmt = 3'd2; e.rs1_used = 1; e.rs2_used = 1;
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        e.fmt = 3'd3; e.rs1_used = 1; e.rs2_used = 1;
        imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.rd_we = 1; imm = {i[31:12], 12'h000}; end
      7'h6F: begin
        e.fmt = 3'd5; e.rd_we = 1;
        imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: begin e.fmt = 3'd7; e.illegal = 1; end
    endcase
    if (i[11:7] == 5'd0) e.rd_we = 0;
    e.imm = imm;
    return e;
  endfunction

  // One clock: scoreboard bookkeeping at the falling edge, then return #1 after the rising edge.
  task automatic cycle();
    exp_t got;
    exp_t exp;
    @(negedge clk);
    n_checks++;
    if (out_valid !== (q.size() != 0))
      $display("FAIL sb_valid: out_valid=%b, required %b", out_valid, q.size() != 0);
    else n_pass++;
    if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() != 0) begin
      exp = q.pop_front();
      got = '{out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7,
              out_fmt, out_imm, out_rs1_used, out_rs2_used, out_rd_we, out_illegal};
      n_checks++;
      if (got !== exp) $display("FAIL sb_entry: got %h, required %h", got, exp);
      else n_pass++;
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; out_ready = 0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_hs: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if (out_imm !== '0 || out_fmt !== 3'd0 || out_pc !== '0 || out_rd_we !== 1'b0)
      $display("FAIL reset_fields: imm=%h fmt=%0d pc=%h we=%b, required zeros", out_imm, out_fmt, out_pc, out_rd_we);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    out_ready = 1; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h100;
    cycle();
    in_valid = 0;
    n_checks++;
    if ({out_valid, out_rs1, out_rs2, out_rd, out_fmt} !== {1'b1, 5'd1, 5'd2, 5'd3, 3'd0})
      $display("FAIL add_fields: v=%b rs1=%0d rs2=%0d rd=%0d fmt=%0d, required 1 1 2 3 0", out_valid, out_rs1, out_rs2, out_rd, out_fmt);
    else n_pass++;
    n_checks++;
    if ({out_imm, out_rs1_used, out_rs2_used, out_rd_we} !== {32'h0, 3'b111})
      $display("FAIL add_ctrl: imm=%h u1=%b u2=%b we=%b, required 0 1 1 1", out_imm, out_rs1_used, out_rs2_used, out_rd_we);
    else n_pass++;
    cycle();
  endtask

  task automatic test_imm();
    out_ready = 1; in_valid = 1; in_instr = 32'hFFF00293; in_pc = 32'h104;
    cycle();
    n_checks++;
    if ({out_fmt, out_rd, out_rs1, out_imm, out_rd_we, out_rs2_used} !== {3'd1, 5'd5, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0})
      $display("FAIL addi: fmt=%0d rd=%0d rs1=%0d imm=%h we=%b u2=%b, required 1 5 0 ffffffff 1 0", out_fmt, out_rd, out_rs1, out_imm, out_rd_we, out_rs2_used);
    else n_pass++;
    in_instr = 32'hFE208EE3; in_pc = 32'h108;
    cycle();
    n_checks++;
    if ({out_fmt, out_imm, out_rs1_used, out_rs2_used, out_rd_we} !== {3'd3, 32'hFFFFFFFC, 3'b110})
      $display("FAIL beq: fmt=%0d imm=%h u1=%b u2=%b we=%b, required 3 fffffffc 1 1 0", out_fmt, out_imm, out_rs1_used, out_rs2_used, out_rd_we);
    else n_pass++;
    in_instr = 32'h00000013; in_pc = 32'h10C;
    cycle();
    n_checks++;
    if ({out_valid, out_fmt, out_rd_we} !== {1'b1, 3'd1, 1'b0})
      $display("FAIL nop_rd_we: v=%b fmt=%0d we=%b, required 1 1 0", out_valid, out_fmt, out_rd_we);
    else n_pass++;
    in_valid = 0;
    cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h200;
    cycle();
    in_instr = 32'hFFF00293; in_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({in_ready, out_valid, out_rd, out_pc} !== {1'b0, 1'b1, 5'd3, 32'h200})
        $display("FAIL bp_hold: ready=%b v=%b rd=%0d pc=%h, required 0 1 3 200", in_ready, out_valid, out_rd, out_pc);
      else n_pass++;
      cycle();
    end
    out_ready = 1;
    cycle();
    in_valid = 0;
    n_checks++;
    if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd5, 32'h204})
      $display("FAIL bp_nobubble: v=%b rd=%0d pc=%h, required 1 5 204", out_valid, out_rd, out_pc);
    else n_pass++;
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h300;
    cycle();
    flush = 1; in_instr = 32'hFE208EE3; in_pc = 32'h304;
    n_checks++;
    if (in_ready !== 1'b0)
      $display("FAIL flush_ready: in_ready=%b, required 0", in_ready);
    else n_pass++;
    cycle();
    flush = 0; in_valid = 0; out_ready = 1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid: out_valid=%b, required 0", out_valid);
    else n_pass++;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || out_opcode === 7'h63)
      $display("FAIL flush_dropped: v=%b opcode=%h, required 0 and not 63", out_valid, out_opcode);
    else n_pass++;
  endtask

  task automatic test_illegal_and_reset();
    out_ready = 0; in_valid = 1; in_instr = 32'h00000000; in_pc = 32'h400;
    cycle();
    in_valid = 0;
    n_checks++;
    if ({out_valid, out_fmt, out_illegal, out_imm, out_rs1_used, out_rs2_used, out_rd_we} !== {1'b1, 3'd7, 1'b1, 32'h0, 3'b000})
      $display("FAIL illegal: v=%b fmt=%0d ill=%b imm=%h u1=%b u2=%b we=%b, required 1 7 1 0 0 0 0", out_valid, out_fmt, out_illegal, out_imm, out_rs1_used, out_rs2_used, out_rd_we);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midreset: v=%b ready=%b, required 0 1", out_valid, in_ready);
    else n_pass++;
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [6:0] opcs [12];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h2B};
    for (int k = 0; k < 200; k++) begin
      r = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = ($urandom_range(0, 9) == 0) ? r : {r[31:7], opcs[$urandom_range(0, 11)]};
      in_pc     = $urandom();
      cycle();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    cycle();
    cycle();
    n_checks++;
    if (q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL drain: queue=%0d v=%b, required 0 0", q.size(), out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_imm();
    test_backpressure();
    test_flush();
    test_illegal_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
